// File: rtl/fb_fetch_unit.sv
// -----------------------------------------------------------------------------
// fb_fetch_unit : instruction-fetch (IF) stage
//
// Purpose
//   Owns the PC register, selects the next PC (sequential, predicted or
//   corrected), runs the imem request/response handshake, buffers responses in
//   a small in-order fetch queue and presents them through the IF/ID register.
//   The PC is a word address, so the sequential next PC is pc+1.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   imem_req_*         request channel (valid/addr out, ready in)
//   imem_resp_*        in-order response channel (latency >= 1 cycle)
//   pc_src/predict_pc  predicted redirect for the instruction in decode
//   address_src/predict_err_pc, register_rst
//                      misprediction correction / pipeline flush
//   id_ready           decode accepts if_* this cycle
//   if_valid/if_pc/if_inst  IF/ID output register
//
// Configuration macro
//   FB_FETCH_PERF_EN   adds perf_flush_cnt and perf_stall_cnt outputs
// -----------------------------------------------------------------------------

// Credit and overflow checks for the fetch queue.
module fb_fetch_unit_chk #(
  parameter int unsigned CW          = 2,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          resp_valid,
  input logic [CW-1:0] out_cnt,
  input logic [CW-1:0] q_cnt,
  input logic [CW-1:0] drop_cnt
);
  // A kept response must always find a free queue slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(resp_valid && (drop_cnt == {CW{1'b0}}) && (q_cnt == CW'(QUEUE_DEPTH))));

  // Outstanding requests plus queued entries never exceed the queue depth.
  a_credit: assert property (@(posedge clk) disable iff (rst)
    ((out_cnt + q_cnt) <= CW'(QUEUE_DEPTH)));
endmodule

module fb_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,
  input  logic        pc_src,
  input  logic [31:0] predict_pc,
  input  logic        address_src,
  input  logic [31:0] predict_err_pc,
  input  logic        register_rst,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
`ifdef FB_FETCH_PERF_EN
  ,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int unsigned   CW      = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned   PW      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [PW-1:0] LAST_C  = PW'(QUEUE_DEPTH - 1);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_out;                   // accepted, response not yet seen
  logic [CW-1:0] r_cnt;                   // fetch queue occupancy
  logic [CW-1:0] r_drop;                  // in-flight responses to discard
  logic [31:0]   r_pf_pc [QUEUE_DEPTH];   // PCs of in-flight requests
  logic [PW-1:0] r_pf_wr, r_pf_rd;
  logic [31:0]   r_q_pc   [QUEUE_DEPTH];
  logic [31:0]   r_q_inst [QUEUE_DEPTH];
  logic [PW-1:0] r_q_wr, r_q_rd;
  logic          r_if_valid;
  logic [31:0]   r_if_pc, r_if_inst;

  logic          w_req_valid, w_acc, w_resp, w_err, w_pred, w_flush;
  logic          w_discard, w_push, w_pop;
  logic [CW-1:0] w_inflight_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == LAST_C) ? {PW{1'b0}} : p + PW'(1'b1);
  endfunction

  // Credit rule: every request already owns a queue slot for its response.
  assign w_req_valid = !rst && ((r_out + r_cnt) < DEPTH_C);
  assign w_acc       = w_req_valid & imem_req_ready;
  assign w_resp      = imem_resp_valid & (r_out != ZERO_C);
  assign w_err       = address_src | register_rst;
  // A prediction only counts when decode actually takes the branch.
  assign w_pred      = pc_src & r_if_valid & id_ready & ~w_err;
  assign w_flush     = w_err | w_pred;
  assign w_discard   = w_resp & (r_drop != ZERO_C);
  assign w_push      = w_resp & ~w_discard & ~w_flush;
  assign w_pop       = (~r_if_valid | id_ready) & (r_cnt != ZERO_C) & ~w_flush;
  // Everything still owed by imem after this edge.
  assign w_inflight_nxt = r_out + CW'(w_acc) - CW'(w_resp);

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign if_valid       = r_if_valid;
  assign if_pc          = r_if_pc;
  assign if_inst        = r_if_inst;

  // PC register: correction beats prediction beats sequential advance.
  always_ff @(posedge clk) begin
    if (rst)         r_pc <= RESET_PC;
    else if (w_err)  r_pc <= predict_err_pc;
    else if (w_pred) r_pc <= predict_pc;
    else if (w_acc)  r_pc <= r_pc + 32'd1;
  end

  // Outstanding-request and drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= ZERO_C;
      r_drop <= ZERO_C;
    end else begin
      r_out <= w_inflight_nxt;
      if (w_flush)        r_drop <= w_inflight_nxt;
      else if (w_discard) r_drop <= r_drop - CW'(1'b1);
    end
  end

  // In-flight PC FIFO pointers; drained by every response, kept or dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pf_wr <= {PW{1'b0}};
      r_pf_rd <= {PW{1'b0}};
    end else begin
      if (w_acc)  r_pf_wr <= ptr_inc(r_pf_wr);
      if (w_resp) r_pf_rd <= ptr_inc(r_pf_rd);
    end
  end

  // In-flight PC FIFO storage.
  always_ff @(posedge clk) begin
    if (w_acc) r_pf_pc[r_pf_wr] <= r_pc;
  end

  // Fetch queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_q_wr <= {PW{1'b0}};
      r_q_rd <= {PW{1'b0}};
      r_cnt  <= ZERO_C;
    end else begin
      if (w_push) r_q_wr <= ptr_inc(r_q_wr);
      if (w_pop)  r_q_rd <= ptr_inc(r_q_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Fetch queue storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_q_wr]   <= r_pf_pc[r_pf_rd];
      r_q_inst[r_q_wr] <= imem_resp_inst;
    end
  end

  // IF/ID output register; holds its contents while decode stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'h0000_0000;
      r_if_inst  <= NOP;
    end else if (w_flush) begin
      r_if_valid <= 1'b0;
    end else if (w_pop) begin
      r_if_valid <= 1'b1;
      r_if_pc    <= r_q_pc[r_q_rd];
      r_if_inst  <= r_q_inst[r_q_rd];
    end else if (id_ready) begin
      r_if_valid <= 1'b0;
    end
  end

`ifdef FB_FETCH_PERF_EN
  logic [31:0] r_perf_flush, r_perf_stall;

  // Performance counters: correction redirects and decode stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_flush <= 32'h0000_0000;
      r_perf_stall <= 32'h0000_0000;
    end else begin
      if (w_err)                    r_perf_flush <= r_perf_flush + 32'd1;
      if (r_if_valid && !id_ready)  r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_flush_cnt = r_perf_flush;
  assign perf_stall_cnt = r_perf_stall;
`endif

  fb_fetch_unit_chk #(.CW(CW), .QUEUE_DEPTH(QUEUE_DEPTH)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .resp_valid (imem_resp_valid),
    .out_cnt    (r_out),
    .q_cnt      (r_cnt),
    .drop_cnt   (r_drop)
  );
endmodule

// File: tb/tb_fb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fb_fetch_unit : self-checking bench for fb_fetch_unit.
// A driver process issues randomized stimulus and serves an in-order imem with
// random latency. A negedge monitor keeps the reference model: the program
// stream decode must see (a queue of expected PCs refilled on each redirect)
// and the expected next request address, and compares whatever the DUT shows.
// -----------------------------------------------------------------------------
module tb_fb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          NCYC     = 3000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        pc_src;
  logic [31:0] predict_pc;
  logic        address_src;
  logic [31:0] predict_err_pc;
  logic        register_rst;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef FB_FETCH_PERF_EN
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fb_fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_inst  (imem_resp_inst),
    .pc_src          (pc_src),
    .predict_pc      (predict_pc),
    .address_src     (address_src),
    .predict_err_pc  (predict_err_pc),
    .register_rst    (register_rst),
    .id_ready        (id_ready),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
`ifdef FB_FETCH_PERF_EN
    ,
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];      // imem model: accepted requests awaiting response
  logic [31:0] exp_q[$];     // reference: upcoming PCs decode must receive
  logic [31:0] exp_tail;
  logic [31:0] exp_req;      // reference: next request address
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cycle = 0;
  int          lat_max = 1;

  // Instruction memory contents, a fixed function of the word address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic refill(input logic [31:0] target);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(target + 32'(i));
    exp_tail = target + 32'd7;
  endtask

  // Driver and imem responder: inputs change 1 time unit after the rising edge.
  initial begin
    pend_t e;
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_inst = 32'h0; pc_src = 1'b0; predict_pc = 32'h0;
    address_src = 1'b0; predict_err_pc = 32'h0; register_rst = 1'b0;
    id_ready = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cycle = c;
      rst = (c < 3) || (c >= 1500 && c < 1503);
      address_src = 1'b0; register_rst = 1'b0; pc_src = 1'b0;
      predict_pc = 32'($urandom_range(0, 255));
      predict_err_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE
                                                   : 32'($urandom_range(0, 255));
      if (c < 43) begin
        id_ready = 1'b1; imem_req_ready = 1'b1; lat_max = 1;
      end else if (c < 49) begin
        id_ready = 1'b0; imem_req_ready = 1'b1; lat_max = 1;
      end else begin
        int r;
        lat_max = 3;
        id_ready = ($urandom_range(0, 9) < 7);
        imem_req_ready = ($urandom_range(0, 9) < 8);
        r = $urandom_range(0, 99);
        address_src = (r < 2);
        register_rst = (r == 2);
        pc_src = ($urandom_range(0, 9) == 0);
      end
      if (c == 60) begin
        address_src = 1'b1; predict_err_pc = 32'hFFFF_FFFF;
        pc_src = 1'b1; predict_pc = 32'h0000_0040;
      end
      if (rst) pend.delete();
      imem_resp_valid = 1'b0;
      imem_resp_inst = 32'h0;
      if (!rst && pend.size() > 0 && pend[0].due <= c &&
          (lat_max == 1 || $urandom_range(0, 3) != 0)) begin
        e = pend.pop_front();
        imem_resp_valid = 1'b1;
        imem_resp_inst = mem(e.addr);
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Monitor and reference model, sampled mid-cycle.
  bit          rst_seen = 1'b0;
  bit          lat_done = 1'b0;
  int          first_acc = -1;
  int          idle = 0;
  int unsigned m_flush = 0;
  int unsigned m_stall = 0;

  always @(negedge clk) begin
    bit hs;
    logic [31:0] e;
    if (rst) begin
      chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      if (rst_seen) begin
        chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_inst", if_inst, NOP);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
      end
      rst_seen = 1'b1;
      refill(RESET_PC);
      exp_req = RESET_PC;
      m_flush = 0; m_stall = 0; idle = 0;
    end else begin
      rst_seen = 1'b0;
`ifdef FB_FETCH_PERF_EN
      chk("perf_flush_cnt", perf_flush_cnt, m_flush);
      chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
      hs = if_valid && id_ready;
      if (if_valid) begin
        chk("if_pc", if_pc, exp_q[0]);
        chk("if_inst", if_inst, mem(exp_q[0]));
        if (!lat_done && first_acc >= 0) begin
          chk("first_valid_latency", 32'(cycle - first_acc), 32'd3);
          lat_done = 1'b1;
        end
      end
      if (hs) begin
        e = exp_q.pop_front();
        exp_tail = exp_tail + 32'd1;
        exp_q.push_back(exp_tail);
        idle = 0;
      end else begin
        idle++;
        if (idle == 300) chk("progress_timeout", 32'(idle), 32'd0);
      end
      if (cycle == 48) chk("stall_req_valid_low", {31'h0, imem_req_valid}, 32'h0);
      if (imem_req_valid && imem_req_ready) begin
        pend_t p;
        chk("req_addr", imem_req_addr, exp_req);
        exp_req = exp_req + 32'd1;
        p.addr = imem_req_addr;
        p.due  = cycle + $urandom_range(1, lat_max);
        pend.push_back(p);
        if (first_acc < 0) first_acc = cycle;
      end
      if (address_src || register_rst) begin
        refill(predict_err_pc);
        exp_req = predict_err_pc;
        m_flush++;
      end else if (pc_src && hs) begin
        refill(predict_pc);
        exp_req = predict_pc;
      end
      if (if_valid && !id_ready) m_stall++;
    end
  end
endmodule
